// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline sequencer.
//   state_t   : sequencer states (BOOT, RUN, DRAIN, HALTED)
//   fwd_sel_t : EX operand source select (register file, WB, MEM)
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_RUN,
    ST_DRAIN,
    ST_HALTED
  } state_t;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_fwd_unit.sv
// fwd_unit: combinational operand-forwarding select for one EX source operand.
// Ports:
//   ex_rs                       in  RAW  source register read by EX
//   mem_rd / mem_reg_write      in       MEM-stage destination and write flag
//   wb_rd  / wb_reg_write       in       WB-stage destination and write flag
//   fwd_sel                     out 2    00 regfile, 01 WB, 10 MEM
// The younger MEM result wins over WB; x0 is never forwarded.
module fwd_unit
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned RAW = 5
) (
  input  logic [RAW-1:0] ex_rs,
  input  logic [RAW-1:0] mem_rd,
  input  logic           mem_reg_write,
  input  logic [RAW-1:0] wb_rd,
  input  logic           wb_reg_write,
  output logic [1:0]     fwd_sel
);

  logic w_mem_hit;
  logic w_wb_hit;

  assign w_mem_hit = mem_reg_write && (mem_rd != '0) && (mem_rd == ex_rs);
  assign w_wb_hit  = wb_reg_write  && (wb_rd  != '0) && (wb_rd  == ex_rs);

  always_comb begin
    fwd_sel = FWD_RF;
    if (w_mem_hit)     fwd_sel = FWD_MEM;
    else if (w_wb_hit) fwd_sel = FWD_WB;
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: central sequencer for a 5-stage RISC-V pipeline.
// Boots the PC, resolves load-use stalls, taken-branch flushes and operand
// forwarding, and on a halt request drains the pipe and freezes the core.
// Only enables, flushes and mux selects are driven; no datapath storage.
// Ports:
//   clk, reset (sync, active-low), initial_address, tr (halt request)
//   id_rs1/id_rs2, ex_rs1/ex_rs2, ex_rd, ex_mem_read, ex_branch_taken,
//   ex_branch_target, mem_rd, wb_rd, mem_reg_write, wb_reg_write
//   pc_we, pc_load, pc_load_addr, ifid_we, ifid_flush, idex_flush,
//   fwd_a_sel, fwd_b_sel, halted
// Optional: define PIPE_PERF_CNT_EN to add perf_cycles, perf_stalls,
//   perf_flushes (32-bit wrapping counters, frozen while HALTED).
module pipeline_hazard_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned RAW          = 5,
  parameter int unsigned DRAIN_CYCLES = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] initial_address,
  input  logic            tr,
  input  logic [RAW-1:0]  id_rs1,
  input  logic [RAW-1:0]  id_rs2,
  input  logic [RAW-1:0]  ex_rs1,
  input  logic [RAW-1:0]  ex_rs2,
  input  logic [RAW-1:0]  ex_rd,
  input  logic            ex_mem_read,
  input  logic            ex_branch_taken,
  input  logic [XLEN-1:0] ex_branch_target,
  input  logic [RAW-1:0]  mem_rd,
  input  logic [RAW-1:0]  wb_rd,
  input  logic            mem_reg_write,
  input  logic            wb_reg_write,
  output logic            pc_we,
  output logic            pc_load,
  output logic [XLEN-1:0] pc_load_addr,
  output logic            ifid_we,
  output logic            ifid_flush,
  output logic            idex_flush,
  output logic [1:0]      fwd_a_sel,
  output logic [1:0]      fwd_b_sel,
  output logic            halted
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [31:0]     perf_cycles,
  output logic [31:0]     perf_stalls,
  output logic [31:0]     perf_flushes
`endif
);

  localparam int unsigned CNT_W = $clog2(DRAIN_CYCLES + 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_drain_cnt;
  logic [CNT_W-1:0] w_drain_cnt_nxt;
  logic             w_lu;

  assign w_lu = ex_mem_read && (ex_rd != '0) &&
                ((ex_rd == id_rs1) || (ex_rd == id_rs2));

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= ST_BOOT;
      r_drain_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_drain_cnt <= w_drain_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_drain_cnt_nxt = r_drain_cnt;
    pc_we           = 1'b1;
    pc_load         = 1'b0;
    pc_load_addr    = initial_address;
    ifid_we         = 1'b1;
    ifid_flush      = 1'b0;
    idex_flush      = 1'b0;
    halted          = 1'b0;
    // Boot outputs are also forced while reset is held low, whatever the
    // registered state currently is.
    if (!reset || (r_state == ST_BOOT)) begin
      pc_we       = 1'b0;
      pc_load     = 1'b1;
      ifid_we     = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      w_state_nxt = ST_RUN;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (ex_branch_taken) begin
            pc_load      = 1'b1;
            pc_load_addr = ex_branch_target;
            ifid_flush   = 1'b1;
            idex_flush   = 1'b1;
          end else if (w_lu) begin
            pc_we      = 1'b0;
            ifid_we    = 1'b0;
            idex_flush = 1'b1;
          end
          if (tr) begin
            w_state_nxt     = ST_DRAIN;
            w_drain_cnt_nxt = CNT_W'(DRAIN_CYCLES);
          end
        end
        ST_DRAIN: begin
          pc_we = 1'b0;
          if (w_lu) begin
            ifid_we    = 1'b0;
            idex_flush = 1'b1;
          end else begin
            ifid_flush = 1'b1;
            if (r_drain_cnt == CNT_W'(1)) begin
              w_state_nxt     = ST_HALTED;
              w_drain_cnt_nxt = '0;
            end else begin
              w_drain_cnt_nxt = r_drain_cnt - CNT_W'(1);
            end
          end
        end
        ST_HALTED: begin
          pc_we      = 1'b0;
          ifid_we    = 1'b0;
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          halted     = 1'b1;
        end
        default: w_state_nxt = ST_BOOT;
      endcase
    end
  end

  fwd_unit #(.RAW(RAW)) u_fwd_a (
    .ex_rs         (ex_rs1),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .fwd_sel       (fwd_a_sel)
  );

  fwd_unit #(.RAW(RAW)) u_fwd_b (
    .ex_rs         (ex_rs2),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .fwd_sel       (fwd_b_sel)
  );

`ifdef PIPE_PERF_CNT_EN
  logic        w_active;
  logic        w_stall;
  logic        w_redirect;
  logic [31:0] r_perf_cycles;
  logic [31:0] r_perf_stalls;
  logic [31:0] r_perf_flushes;

  // A load-use hazard in RUN is only a stall when no branch redirect wins.
  assign w_active   = (r_state == ST_RUN) || (r_state == ST_DRAIN);
  assign w_redirect = (r_state == ST_RUN) && ex_branch_taken;
  assign w_stall    = w_lu && ((r_state == ST_DRAIN) ||
                               ((r_state == ST_RUN) && !ex_branch_taken));

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_perf_cycles  <= '0;
      r_perf_stalls  <= '0;
      r_perf_flushes <= '0;
    end else begin
      if (w_active)   r_perf_cycles  <= r_perf_cycles  + 32'd1;
      if (w_stall)    r_perf_stalls  <= r_perf_stalls  + 32'd1;
      if (w_redirect) r_perf_flushes <= r_perf_flushes + 32'd1;
    end
  end

  assign perf_cycles  = r_perf_cycles;
  assign perf_stalls  = r_perf_stalls;
  assign perf_flushes = r_perf_flushes;
`endif

endmodule
